// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution stage.
// Contents:
//   br_op_e        - 3-bit compare op encoding (EQ, NE, LTZ, GEZ, GTZ, LEZ, LT, LTU)
//   BHT_*          - 2-bit saturating counter states
//   br_flags_t     - single-bit fields of the result register
//   BRANCH_DEFAULT - reset/idle value of those fields
//   br_compare     - selects the branch outcome from precomputed compare flags
//   bht_next       - saturating counter update
package branch_pkg;

  typedef enum logic [2:0] {
    BR_OP_EQ  = 3'd0,
    BR_OP_NE  = 3'd1,
    BR_OP_LTZ = 3'd2,
    BR_OP_GEZ = 3'd3,
    BR_OP_GTZ = 3'd4,
    BR_OP_LEZ = 3'd5,
    BR_OP_LT  = 3'd6,
    BR_OP_LTU = 3'd7
  } br_op_e;

  localparam logic [1:0] BHT_SNT = 2'b00;
  localparam logic [1:0] BHT_WNT = 2'b01;
  localparam logic [1:0] BHT_WT  = 2'b10;
  localparam logic [1:0] BHT_ST  = 2'b11;

  typedef struct packed {
    logic valid;
    logic taken;
    logic redirect;
  } br_flags_t;

  localparam br_flags_t BRANCH_DEFAULT = '{valid: 1'b0, taken: 1'b0, redirect: 1'b0};

  // The comparators are built in the caller at the operand width; this
  // function only picks the relevant flag, so it stays width-independent.
  function automatic logic br_compare(
    input br_op_e op,
    input logic   eq,
    input logic   rs_zero,
    input logic   rs_neg,
    input logic   lt_s,
    input logic   lt_u
  );
    logic taken;
    taken = 1'b0;
    case (op)
      BR_OP_EQ:  taken = eq;
      BR_OP_NE:  taken = !eq;
      BR_OP_LTZ: taken = rs_neg;
      BR_OP_GEZ: taken = !rs_neg;
      BR_OP_GTZ: taken = !rs_neg && !rs_zero;
      BR_OP_LEZ: taken = rs_neg || rs_zero;
      BR_OP_LT:  taken = lt_s;
      BR_OP_LTU: taken = lt_u;
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

  function automatic logic [1:0] bht_next(input logic [1:0] state, input logic taken);
    logic [1:0] nxt;
    nxt = state;
    if (taken) begin
      if (state != BHT_ST) nxt = state + 2'd1;
    end else begin
      if (state != BHT_SNT) nxt = state - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Bus bundle between the ID stage / fetch (master) and branch_resolve (slave).
// Request:  br_valid_i, br_ready_o, br_op_i, rs_data_i, rt_data_i, pc_i,
//           offset_i, pred_taken_i
// Result:   res_valid_o, res_ready_i, res_taken_o, res_target_o, redirect_o
// Control:  flush_i
// Fetch:    fetch_pc_i, pred_taken_o
// Suffixes are from the stage's point of view (_i into branch_resolve).
interface branch_resolve_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int OFF_W  = 16
);
  logic              br_valid_i;
  logic              br_ready_o;
  logic [2:0]        br_op_i;
  logic [DATA_W-1:0] rs_data_i;
  logic [DATA_W-1:0] rt_data_i;
  logic [PC_W-1:0]   pc_i;
  logic [OFF_W-1:0]  offset_i;
  logic              pred_taken_i;
  logic              res_valid_o;
  logic              res_ready_i;
  logic              res_taken_o;
  logic [PC_W-1:0]   res_target_o;
  logic              redirect_o;
  logic              flush_i;
  logic [PC_W-1:0]   fetch_pc_i;
  logic              pred_taken_o;

  modport master (
    output br_valid_i, br_op_i, rs_data_i, rt_data_i, pc_i, offset_i, pred_taken_i,
    output res_ready_i, flush_i, fetch_pc_i,
    input  br_ready_o, res_valid_o, res_taken_o, res_target_o, redirect_o, pred_taken_o
  );

  modport slave (
    input  br_valid_i, br_op_i, rs_data_i, rt_data_i, pc_i, offset_i, pred_taken_i,
    input  res_ready_i, flush_i, fetch_pc_i,
    output br_ready_o, res_valid_o, res_taken_o, res_target_o, redirect_o, pred_taken_o
  );
endinterface

// File: rtl/branch_bht.sv
// Branch history table: ENTRIES 2-bit saturating counters.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (all entries -> BHT_WNT)
//   rd_idx     - async read index
//   rd_taken   - MSB of the addressed counter (predict taken)
//   wr_en      - apply one counter update this edge
//   wr_idx     - entry to update
//   wr_taken   - direction of the update (increment when 1)
// The read path has no write bypass: a same-cycle update is seen next cycle.
module branch_bht
  import branch_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] cnt_vec [ENTRIES];

  // Each counter is its own register so the whole table can be reset
  // asynchronously; this keeps it in fabric flops rather than block RAM.
  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : gen_entry
      localparam logic [IDX_W-1:0] ENTRY_IDX = IDX_W'(gi);
      logic [1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= BHT_WNT;
        end else if (wr_en && (wr_idx == ENTRY_IDX)) begin
          cnt_reg <= bht_next(cnt_reg, wr_taken);
        end
      end

      assign cnt_vec[gi] = cnt_reg;
    end
  endgenerate

  assign rd_taken = cnt_vec[rd_idx][1];

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution stage (ID/EX boundary).
// Evaluates the branch compare, forms taken and fall-through targets, and
// holds the result in a one-deep output register behind valid/ready.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   bus      - branch_resolve_if.slave: request handshake, result handshake,
//              flush, and the fetch-side BHT prediction lookup
// Requires PC_W > OFF_W (offset is sign-extended into the PC width).
module branch_resolve
  import branch_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PC_W        = 32,
  parameter int OFF_W       = 16,
  parameter int BHT_ENTRIES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resolve_if.slave      bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  // Compare flags at full operand width
  logic eq_flag, rs_zero_flag, rs_neg_flag, lt_s_flag, lt_u_flag;
  logic taken_comb;

  assign eq_flag      = (bus.rs_data_i == bus.rt_data_i);
  assign rs_zero_flag = (bus.rs_data_i == '0);
  assign rs_neg_flag  = bus.rs_data_i[DATA_W-1];
  assign lt_s_flag    = ($signed(bus.rs_data_i) < $signed(bus.rt_data_i));
  assign lt_u_flag    = (bus.rs_data_i < bus.rt_data_i);
  assign taken_comb   = br_compare(br_op_e'(bus.br_op_i), eq_flag, rs_zero_flag,
                                   rs_neg_flag, lt_s_flag, lt_u_flag);

  // Target arithmetic wraps modulo 2^PC_W
  logic [PC_W-1:0] off_bytes;
  logic [PC_W-1:0] fall_pc;
  logic [PC_W-1:0] taken_pc;

  assign off_bytes = {{(PC_W-OFF_W){bus.offset_i[OFF_W-1]}}, bus.offset_i} << 2;
  assign fall_pc   = bus.pc_i + PC_W'(4);
  assign taken_pc  = fall_pc + off_bytes;

  // Output register
  br_flags_t        flags_reg, flags_next;
  logic [PC_W-1:0]  target_reg, target_next;
  logic [IDX_W-1:0] idx_reg, idx_next;

  logic capture, accept;

  assign bus.br_ready_o = !flags_reg.valid || bus.res_ready_i;
  assign capture        = bus.br_valid_i && bus.br_ready_o && !bus.flush_i;
  assign accept         = flags_reg.valid && bus.res_ready_i && !bus.flush_i;

  always_comb begin
    flags_next  = flags_reg;
    target_next = target_reg;
    idx_next    = idx_reg;
    if (bus.flush_i) begin
      // Only the valid bit is dropped; the payload simply goes stale.
      flags_next.valid = 1'b0;
    end else if (capture) begin
      flags_next.valid    = 1'b1;
      flags_next.taken    = taken_comb;
      flags_next.redirect = (taken_comb != bus.pred_taken_i);
      target_next         = taken_comb ? taken_pc : fall_pc;
      idx_next            = bus.pc_i[IDX_W+1:2];
    end else if (accept) begin
      flags_next.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_reg  <= BRANCH_DEFAULT;
      target_reg <= '0;
      idx_reg    <= '0;
    end else begin
      flags_reg  <= flags_next;
      target_reg <= target_next;
      idx_reg    <= idx_next;
    end
  end

  assign bus.res_valid_o  = flags_reg.valid;
  assign bus.res_taken_o  = flags_reg.taken;
  assign bus.redirect_o   = flags_reg.redirect;
  assign bus.res_target_o = target_reg;

  // The BHT learns from the result being retired, using the index latched
  // at capture, so a simultaneous capture cannot disturb the update.
  branch_bht #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (bus.fetch_pc_i[IDX_W+1:2]),
    .rd_taken (bus.pred_taken_o),
    .wr_en    (accept),
    .wr_idx   (idx_reg),
    .wr_taken (flags_reg.taken)
  );

  // Only the index bits of the fetch PC select a BHT entry.
  logic fetch_pc_unused;
  assign fetch_pc_unused = &{1'b0, bus.fetch_pc_i};

endmodule

// File: tb/tb_branch_resolve.sv
// Testbench for branch_resolve: directed steps followed by random traffic,
// all checked against a transaction-level reference model.
module tb_branch_resolve;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int OFF_W  = 16;
  localparam int NENT   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_if #(.DATA_W(DATA_W), .PC_W(PC_W), .OFF_W(OFF_W)) bus ();

  branch_resolve #(
    .DATA_W(DATA_W), .PC_W(PC_W), .OFF_W(OFF_W), .BHT_ENTRIES(NENT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          bht [NENT];
  bit          m_valid;
  bit          m_taken;
  bit          m_redirect;
  logic [31:0] m_target;
  int          m_idx;

  function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    int srs, srt;
    srs = int'(rs);
    srt = int'(rt);
    case (op)
      3'd0: return rs == rt;
      3'd1: return rs != rt;
      3'd2: return srs < 0;
      3'd3: return srs >= 0;
      3'd4: return srs > 0;
      3'd5: return srs <= 0;
      3'd6: return srs < srt;
      default: return rs < rt;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) bht[i] = 1;
    m_valid = 0; m_taken = 0; m_redirect = 0; m_target = 0; m_idx = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int fi;
    fi = int'(bus.fetch_pc_i[5:2]);
    check({tag, ".ready"},    32'(bus.br_ready_o),   32'(!m_valid || bus.res_ready_i));
    check({tag, ".valid"},    32'(bus.res_valid_o),  32'(m_valid));
    check({tag, ".taken"},    32'(bus.res_taken_o),  32'(m_taken));
    check({tag, ".target"},   bus.res_target_o,      m_target);
    check({tag, ".redirect"}, 32'(bus.redirect_o),   32'(m_redirect));
    check({tag, ".pred"},     32'(bus.pred_taken_o), 32'(bht[fi] >= 2));
  endtask

  // Advance one clock: check at the falling edge, update the model with the
  // inputs as they stand, then let the rising edge happen.
  task automatic step(input string tag);
    bit rdy, cap, acc, t;
    int off;
    @(negedge clk);
    check_outputs(tag);
    rdy = !m_valid || bus.res_ready_i;
    cap = bus.br_valid_i && rdy && !bus.flush_i;
    acc = m_valid && bus.res_ready_i && !bus.flush_i;
    if (acc) begin
      if (m_taken) bht[m_idx] = (bht[m_idx] == 3) ? 3 : bht[m_idx] + 1;
      else         bht[m_idx] = (bht[m_idx] == 0) ? 0 : bht[m_idx] - 1;
    end
    if (bus.flush_i) begin
      m_valid = 0;
    end else if (cap) begin
      t   = ref_taken(bus.br_op_i, bus.rs_data_i, bus.rt_data_i);
      off = int'($signed(bus.offset_i));
      m_valid    = 1;
      m_taken    = t;
      m_redirect = (t != bus.pred_taken_i);
      m_target   = t ? 32'(bus.pc_i + 4 + off * 4) : 32'(bus.pc_i + 4);
      m_idx      = int'(bus.pc_i[5:2]);
    end else if (acc) begin
      m_valid = 0;
    end
    $display("step %s: valid=%0b rdy=%0b flush=%0b cap=%0b acc=%0b op=%0d pc=%0h -> exp valid=%0b taken=%0b tgt=%0h",
             tag, bus.br_valid_i, bus.res_ready_i, bus.flush_i, cap, acc, bus.br_op_i, bus.pc_i,
             m_valid, m_taken, m_target);
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit v, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                     input logic [31:0] pc, input logic [15:0] off, input bit pred);
    bus.br_valid_i   = v;
    bus.br_op_i      = op;
    bus.rs_data_i    = rs;
    bus.rt_data_i    = rt;
    bus.pc_i         = pc;
    bus.offset_i     = off;
    bus.pred_taken_i = pred;
  endtask

  task automatic check_all_reset(input string tag);
    for (int i = 0; i < NENT; i++) begin
      bus.fetch_pc_i = 32'(i * 4);
      #1;
      check({tag, ".pred_rst"}, 32'(bus.pred_taken_o), 32'd0);
    end
    check({tag, ".valid_rst"},  32'(bus.res_valid_o), 32'd0);
    check({tag, ".taken_rst"},  32'(bus.res_taken_o), 32'd0);
    check({tag, ".target_rst"}, bus.res_target_o,     32'd0);
    check({tag, ".redir_rst"},  32'(bus.redirect_o),  32'd0);
    check({tag, ".ready_rst"},  32'(bus.br_ready_o),  32'd1);
  endtask

  initial begin
    model_reset();
    req(0, 3'd0, 0, 0, 0, 0, 0);
    bus.res_ready_i = 1'b1;
    bus.flush_i     = 1'b0;
    bus.fetch_pc_i  = 32'h40;
    repeat (2) @(posedge clk);
    #1;
    check_all_reset("reset");
    rst = 1'b0;
    bus.fetch_pc_i = 32'h40;
    step("idle");

    // EQ taken with backward offset, mispredicted
    req(1, 3'd0, 5, 5, 32'h100, 16'hFFFE, 0);
    step("eq_cap");
    req(0, 3'd0, 0, 0, 0, 0, 0);
    check("eq.taken",    32'(bus.res_taken_o), 32'd1);
    check("eq.target",   bus.res_target_o,     32'hFC);
    check("eq.redirect", 32'(bus.redirect_o),  32'd1);
    step("eq_acc");

    // Signed vs unsigned less-than on the same operands
    req(1, 3'd6, 32'hFFFF_FFFF, 1, 32'h200, 16'h0010, 1);
    step("lt_cap");
    req(1, 3'd7, 32'hFFFF_FFFF, 1, 32'h300, 16'h0010, 1);
    check("lt.taken", 32'(bus.res_taken_o), 32'd1);
    step("ltu_cap");
    req(0, 3'd0, 0, 0, 0, 0, 0);
    check("ltu.taken",  32'(bus.res_taken_o), 32'd0);
    check("ltu.target", bus.res_target_o,     32'h304);
    step("ltu_acc");
    step("drain");

    // BHT training at pc 0x40: two taken, then saturate at strong-NT
    bus.fetch_pc_i = 32'h40;
    for (int i = 0; i < 2; i++) begin
      req(1, 3'd0, 7, 7, 32'h40, 16'h0004, 0);
      step("bht_t");
    end
    req(0, 3'd0, 0, 0, 0, 0, 0);
    step("bht_t_drain");
    check("bht.after_2t", 32'(bus.pred_taken_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      req(1, 3'd1, 7, 7, 32'h40, 16'h0004, 1);
      step("bht_nt");
    end
    req(0, 3'd0, 0, 0, 0, 0, 0);
    step("bht_nt_drain");
    check("bht.after_nt", 32'(bus.pred_taken_o), 32'd0);
    req(1, 3'd0, 1, 1, 32'h40, 16'h0004, 0);
    step("bht_t1");
    req(0, 3'd0, 0, 0, 0, 0, 0);
    step("bht_t1_drain");
    check("bht.no_wrap", 32'(bus.pred_taken_o), 32'd0);

    // Backpressure: three stalled cycles with a waiting request
    req(1, 3'd3, 32'h10, 0, 32'h500, 16'h0020, 0);
    step("bp_cap");
    bus.res_ready_i = 1'b0;
    req(1, 3'd2, 32'h10, 0, 32'h600, 16'h0008, 0);
    for (int i = 0; i < 3; i++) begin
      step("bp_hold");
      check("bp.ready_low",  32'(bus.br_ready_o),  32'd0);
      check("bp.target_hold", bus.res_target_o, 32'h584);
    end
    bus.res_ready_i = 1'b1;
    step("bp_release");
    req(0, 3'd0, 0, 0, 0, 0, 0);
    check("bp.new_target", bus.res_target_o, 32'h604);

    // Flush with a pending result being accepted and a new request offered
    bus.fetch_pc_i = 32'h600;
    req(1, 3'd0, 3, 3, 32'h700, 16'h0001, 0);
    bus.flush_i = 1'b1;
    step("flush");
    bus.flush_i = 1'b0;
    req(0, 3'd0, 0, 0, 0, 0, 0);
    check("flush.valid", 32'(bus.res_valid_o), 32'd0);
    step("flush_after");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      req($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
          ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom,
          ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom,
          32'($urandom_range(0, 255) * 4), 16'($urandom), 1'($urandom));
      bus.res_ready_i = $urandom_range(0, 3) != 0;
      bus.flush_i     = $urandom_range(0, 15) == 0;
      bus.fetch_pc_i  = 32'($urandom_range(0, 255) * 4);
      step("rand");
    end

    // Reset during backpressure: result dropped, BHT restored
    bus.flush_i = 1'b0;
    req(1, 3'd0, 9, 9, 32'h40, 16'h0002, 1);
    step("rb_cap");
    bus.res_ready_i = 1'b0;
    step("rb_hold");
    rst = 1'b1;
    #1;
    model_reset();
    check_all_reset("midrst");
    rst = 1'b0;
    bus.res_ready_i = 1'b1;
    req(0, 3'd0, 0, 0, 0, 0, 0);
    bus.fetch_pc_i = 32'h40;
    step("post_rst");
    step("post_rst2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
